// File: rtl/jk_excitation_driver.sv
`default_nettype none
// ============================================================================
//  Module   : jk_excitation_driver
//  Purpose  : Drives the J/K inputs of an external JK flip-flop so that its Q
//             reaches a requested next-state bit. Each result is checked
//             against the flip-flop feedback, and misses are counted.
//  Revision : 1.0  initial release
// ============================================================================
module jk_excitation_driver #(
   parameter logic XVAL  = 1'b0,
   parameter int   ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in_target,
   output logic             in_ready,
   input  logic             q_fb,
   output logic             J,
   output logic             K,
   output logic             q_exp,
   output logic             mismatch,
   output logic [ERR_W-1:0] err_count,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_SYNC  = 2'd0,
      S_IDLE  = 2'd1,
      S_DRIVE = 2'd2,
      S_CHECK = 2'd3
   } state_t;

   localparam logic [ERR_W-1:0] C_ERR_MAX = {ERR_W{1'b1}};
   localparam logic [ERR_W-1:0] C_ERR_ONE = ERR_W'(1);

   state_t           r_state,    w_state_nxt;
   logic             r_target,   w_target_nxt;
   logic             r_j,        w_j_nxt;
   logic             r_k,        w_k_nxt;
   logic             r_q_exp,    w_q_exp_nxt;
   logic             r_mismatch, w_mismatch_nxt;
   logic [ERR_W-1:0] r_err,      w_err_nxt;
   logic             w_j_exc;
   logic             w_k_exc;

   // Excitation table: the input that does not matter for a transition gets XVAL
   always_comb begin
      w_j_exc = 1'b0;
      w_k_exc = 1'b0;
      case ({r_q_exp, in_target})
         2'b00:   begin w_j_exc = 1'b0; w_k_exc = XVAL; end
         2'b01:   begin w_j_exc = 1'b1; w_k_exc = XVAL; end
         2'b10:   begin w_j_exc = XVAL; w_k_exc = 1'b1; end
         default: begin w_j_exc = XVAL; w_k_exc = 1'b0; end
      endcase
   end

   // Next-state and next-output logic; J/K default to hold (0,0) outside DRIVE
   always_comb begin
      w_state_nxt    = r_state;
      w_target_nxt   = r_target;
      w_j_nxt        = 1'b0;
      w_k_nxt        = 1'b0;
      w_q_exp_nxt    = r_q_exp;
      w_mismatch_nxt = 1'b0;
      w_err_nxt      = r_err;
      case (r_state)
         S_SYNC: begin
            w_q_exp_nxt = q_fb;
            w_state_nxt = S_IDLE;
         end
         S_IDLE: begin
            if (in_valid) begin
               w_target_nxt = in_target;
               w_j_nxt      = w_j_exc;
               w_k_nxt      = w_k_exc;
               w_state_nxt  = S_DRIVE;
            end
         end
         S_DRIVE: begin
            // Flip-flop samples J/K on this edge; they fall back to 0 after it
            w_state_nxt = S_CHECK;
         end
         default: begin
            // CHECK: q_fb now reflects the edge that ended DRIVE
            if (q_fb != r_target) begin
               w_mismatch_nxt = 1'b1;
               if (r_err != C_ERR_MAX) begin
                  w_err_nxt = r_err + C_ERR_ONE;
               end
            end
            w_q_exp_nxt = q_fb;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State and output registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_SYNC;
         r_target   <= 1'b0;
         r_j        <= 1'b0;
         r_k        <= 1'b0;
         r_q_exp    <= 1'b0;
         r_mismatch <= 1'b0;
         r_err      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_target   <= w_target_nxt;
         r_j        <= w_j_nxt;
         r_k        <= w_k_nxt;
         r_q_exp    <= w_q_exp_nxt;
         r_mismatch <= w_mismatch_nxt;
         r_err      <= w_err_nxt;
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign J         = r_j;
   assign K         = r_k;
   assign q_exp     = r_q_exp;
   assign mismatch  = r_mismatch;
   assign err_count = r_err;

endmodule
`default_nettype wire

// File: tb/tb_jk_excitation_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jk_excitation_driver
//  Purpose  : Directed self-checking bench for jk_excitation_driver. Instance
//             A uses default parameters; instance B uses XVAL=1, ERR_W=2.
//             Each instance drives its own behavioural JK flip-flop.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jk_excitation_driver;

   logic       clk;
   int         vectors;
   int         miscompares;

   // Instance A signals
   logic       rst_n_a, in_valid_a, in_target_a, in_ready_a, q_fb_a;
   logic       j_a, k_a, q_exp_a, mismatch_a, busy_a;
   logic [7:0] err_a;
   logic       ff_q_a, ld_a, ldv_a, frz_a;

   // Instance B signals
   logic       rst_n_b, in_valid_b, in_target_b, in_ready_b, q_fb_b;
   logic       j_b, k_b, q_exp_b, mismatch_b, busy_b;
   logic [1:0] err_b;
   logic       ff_q_b, ld_b, ldv_b, frz_b;

   jk_excitation_driver dut_a (
      .clk       (clk),
      .rst_n     (rst_n_a),
      .in_valid  (in_valid_a),
      .in_target (in_target_a),
      .in_ready  (in_ready_a),
      .q_fb      (q_fb_a),
      .J         (j_a),
      .K         (k_a),
      .q_exp     (q_exp_a),
      .mismatch  (mismatch_a),
      .err_count (err_a),
      .busy      (busy_a)
   );

   jk_excitation_driver #(.XVAL(1'b1), .ERR_W(2)) dut_b (
      .clk       (clk),
      .rst_n     (rst_n_b),
      .in_valid  (in_valid_b),
      .in_target (in_target_b),
      .in_ready  (in_ready_b),
      .q_fb      (q_fb_b),
      .J         (j_b),
      .K         (k_b),
      .q_exp     (q_exp_b),
      .mismatch  (mismatch_b),
      .err_count (err_b),
      .busy      (busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural JK flip-flops; ld presets Q, frz makes Q ignore J/K (stuck)
   always @(posedge clk) begin
      if (ld_a)        ff_q_a <= ldv_a;
      else if (!frz_a) ff_q_a <= (j_a & k_a) ? ~ff_q_a : (j_a ? 1'b1 : (k_a ? 1'b0 : ff_q_a));
   end
   always @(posedge clk) begin
      if (ld_b)        ff_q_b <= ldv_b;
      else if (!frz_b) ff_q_b <= (j_b & k_b) ? ~ff_q_b : (j_b ? 1'b1 : (k_b ? 1'b0 : ff_q_b));
   end
   assign q_fb_a = ff_q_a;
   assign q_fb_b = ff_q_b;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete transaction from an IDLE negedge back to the next IDLE negedge
   task automatic xact(input bit sel, input logic tgt, input logic ej, input logic ek,
                       input logic eq, input logic emm, input int eerr);
      check("ready_before", sel ? in_ready_b : in_ready_a, 1);
      if (sel) begin in_valid_b = 1'b1; in_target_b = tgt; end
      else     begin in_valid_a = 1'b1; in_target_a = tgt; end
      @(negedge clk);
      check("drive_J",     sel ? j_b : j_a, ej);
      check("drive_K",     sel ? k_b : k_a, ek);
      check("drive_busy",  sel ? busy_b : busy_a, 1);
      check("drive_ready", sel ? in_ready_b : in_ready_a, 0);
      if (sel) in_valid_b = 1'b0; else in_valid_a = 1'b0;
      @(negedge clk);
      check("check_J",     sel ? j_b : j_a, 0);
      check("check_K",     sel ? k_b : k_a, 0);
      check("check_mm",    sel ? mismatch_b : mismatch_a, 0);
      @(negedge clk);
      check("idle_mm",     sel ? mismatch_b : mismatch_a, emm);
      check("idle_qexp",   sel ? q_exp_b : q_exp_a, eq);
      check("idle_err",    sel ? 32'(err_b) : 32'(err_a), eerr);
      check("idle_ready",  sel ? in_ready_b : in_ready_a, 1);
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      rst_n_a = 1'b0; in_valid_a = 1'b0; in_target_a = 1'b0;
      rst_n_b = 1'b0; in_valid_b = 1'b0; in_target_b = 1'b0;
      ld_a = 1'b1; ldv_a = 1'b0; frz_a = 1'b0;
      ld_b = 1'b1; ldv_b = 1'b0; frz_b = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_ready", in_ready_a, 0);
      check("rst_busy",  busy_a, 1);
      check("rst_J",     j_a, 0);
      check("rst_K",     k_a, 0);
      check("rst_qexp",  q_exp_a, 0);
      check("rst_mm",    mismatch_a, 0);
      check("rst_err",   err_a, 0);
      ld_a = 1'b0;

      // First edge runs SYNC, ready on the following cycle
      rst_n_a = 1'b1;
      @(negedge clk);
      check("sync_ready", in_ready_a, 1);
      check("sync_busy",  busy_a, 0);
      check("sync_qexp",  q_exp_a, 0);

      // Targets 1,1,0,0 from Q=0 with XVAL=0
      xact(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0);
      xact(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      xact(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      xact(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

      // Stuck-at-0 flip-flop, target 1: one mismatch pulse, err=1, q_exp=0
      frz_a = 1'b1;
      xact(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1);
      @(negedge clk);
      check("mm_one_cycle", mismatch_a, 0);
      check("mm_err_hold",  err_a, 1);
      frz_a = 1'b0;

      // in_valid held for 9 cycles, target 1 from q_exp=0
      in_valid_a = 1'b1; in_target_a = 1'b1;
      for (int cyc = 0; cyc < 9; cyc++) begin
         check("b2b_ready", in_ready_a, (cyc % 3) == 0);
         check("b2b_J",     j_a, cyc == 1);
         check("b2b_K",     k_a, 0);
         @(negedge clk);
      end
      in_valid_a = 1'b0;
      check("b2b_end_ready", in_ready_a, 1);
      check("b2b_end_qexp",  q_exp_a, 1);
      check("b2b_end_err",   err_a, 1);

      // Reset pulsed during DRIVE of target 0 (q_exp=1 -> J=0,K=1)
      in_valid_a = 1'b1; in_target_a = 1'b0;
      @(negedge clk);
      check("pre_rst_K", k_a, 1);
      in_valid_a = 1'b0;
      #1 rst_n_a = 1'b0;
      #1;
      check("async_J",     j_a, 0);
      check("async_K",     k_a, 0);
      check("async_busy",  busy_a, 1);
      check("async_ready", in_ready_a, 0);
      check("async_err",   err_a, 0);
      @(negedge clk);
      rst_n_a = 1'b1;
      @(negedge clk);
      check("resync_qexp",  q_exp_a, 1);
      check("resync_ready", in_ready_a, 1);
      xact(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);

      // Instance B: XVAL=1 toggle, then saturation of a 2-bit counter
      ld_b = 1'b0;
      rst_n_b = 1'b1;
      @(negedge clk);
      check("b_sync_qexp", q_exp_b, 0);
      xact(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0);
      frz_b = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         xact(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, (n > 3) ? 3 : n);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/jk_excitation_driver.md
JK_EXCITATION_DRIVER -- requirements
Module: jk_excitation_driver

Interface
REQ-001 The module SHALL have parameter XVAL, default 0: the value driven on the don't-care input of an excitation pair.
REQ-002 The module SHALL have parameter ERR_W, default 8: the width of the error counter.
REQ-003 clk  input  1  Single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  Asynchronous, active-low reset; one clock domain only.
REQ-005 in_valid  input  1  A target next-state bit is offered.
REQ-006 in_target  input  1  Required next value of the driven flip-flop Q.
REQ-007 in_ready  output  1  The driver accepts a target this cycle.
REQ-008 q_fb  input  1  Q output of the external JK flip-flop, which is clocked by the same clk.
REQ-009 J  output  1  Registered J drive to the flip-flop.
REQ-010 K  output  1  Registered K drive to the flip-flop.
REQ-011 q_exp  output  1  Modelled current Q of the flip-flop.
REQ-012 mismatch  output  1  One-cycle pulse: the checked Q differed from the target.
REQ-013 err_count  output  ERR_W  Saturating count of mismatches.
REQ-014 busy  output  1  High in every state except IDLE.

Function
REQ-015 The FSM SHALL have four states: SYNC, IDLE, DRIVE and CHECK, with state register, J, K, q_exp, mismatch and err_count all registered.
REQ-016 SYNC SHALL last exactly one cycle, load q_exp with q_fb, and then go to IDLE.
REQ-017 IDLE SHALL assert in_ready, and on in_valid&&in_ready SHALL latch in_target, load J/K per REQ-018, and go to DRIVE.
REQ-018 The excitation mapping from (q_exp, target) to (J, K) SHALL be: 0->0 gives (0, XVAL); 0->1 gives (1, XVAL); 1->0 gives (XVAL, 1); 1->1 gives (XVAL, 0).
REQ-019 DRIVE SHALL last one cycle, hold J/K so the flip-flop samples them on the edge that ends DRIVE, then go to CHECK.
REQ-020 On entering CHECK, J and K SHALL return to 0 (hold) and stay 0 in every state other than DRIVE.
REQ-021 On the edge ending CHECK, the driver SHALL compare q_fb with the latched target.
  - If they differ: assert mismatch for the next cycle and increment err_count.
  - In all cases: load q_exp with q_fb (resync to the actual state) and go to IDLE.
REQ-022 err_count SHALL saturate at 2^ERR_W-1 and SHALL never wrap.
REQ-023 Throughput SHALL be one target per 3 cycles: accept edge, DRIVE edge, CHECK edge; in_ready is high one cycle in three under back-to-back valid.
REQ-024 in_target SHALL be ignored while in_ready is low; no input buffering is provided.
REQ-025 mismatch SHALL be low in every cycle that does not directly follow a CHECK with a difference.
REQ-026 A held in_valid SHALL be re-accepted on each IDLE visit as a new target.

Reset
REQ-027 While rst_n is low, the block SHALL hold state=SYNC, J=0, K=0, q_exp=0, mismatch=0, err_count=0, in_ready=0 and busy=1, asynchronously and regardless of clk.
REQ-028 Reset assertion mid-DRIVE or mid-CHECK SHALL drop J/K to 0 immediately and discard the latched target without counting it.
REQ-029 After rst_n deasserts, the first rising edge SHALL execute SYNC, and in_ready SHALL go high on the following cycle.

Verification
REQ-030 Scenario: flip-flop initialised Q=0, targets 1,1,0,0 with XVAL=0 -> J/K sequence (1,0),(0,0),(0,1),(0,0); q_exp 1,1,0,0; err_count=0.
REQ-031 Scenario: XVAL=1, Q=0, target 1 -> J=1, K=1 (toggle); Q becomes 1; no mismatch.
REQ-032 Scenario: q_fb forced stuck at 0, target 1 -> mismatch pulse one cycle after CHECK; err_count=1; q_exp=0.
REQ-033 Scenario: ERR_W=2 with stuck q_fb and 5 failing targets -> err_count saturates at 3.
REQ-034 Scenario: in_valid held high for 9 cycles -> exactly 3 accepts, in_ready pattern 1,0,0 repeating, J=K=0 outside DRIVE.
REQ-035 Scenario: rst_n pulsed low during DRIVE -> J=K=0 within the same cycle, err_count=0, SYNC re-captures q_fb, next accept uses that captured value.
